// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory bootloader: FSM state
// encoding and the default memory geometry used by the instruction memory.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Instruction memory depth in words and byte address of word 0.
  localparam int          DEFAULT_MEM_SIZE  = 512;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles a big-endian 32-bit word from four consecutive stream bytes.
// The first byte of a word ends up in [31:24]. word/word_valid are
// combinational: they present the complete word during the cycle in which
// the 4th byte is being accepted, so the caller can register it on that edge.
module byte_word_packer (
  input  logic        clk,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;

  // Shift in the first three bytes of a word and count byte position 0..3.
  always_ff @(posedge clk) begin
    if (clear) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[15:0], in_byte};
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

  assign word_valid = shift_en && (cnt_reg == 2'd3);

  // Byte lane 0 is the byte arriving now; lanes 1..3 come from the shifter.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    if (gi == 0) begin : g_live
      assign word[7:0] = in_byte;
    end else begin : g_held
      assign word[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Byte-stream bootloader: reads a 16-bit big-endian word count, then that many
// big-endian 32-bit words, writing each into instruction memory. The CPU is
// held in reset until the image is complete.
// Optional build macro INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte covering the header and all data bytes.
module inst_loader
  import loader_pkg::*;
#(
  parameter int          MEM_SIZE  = DEFAULT_MEM_SIZE,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W+1)'(MEM_SIZE);

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = CSUM;
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  state_t           state_reg, state_next;
  logic [7:0]       n_hi_reg;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] idx_reg;
  logic [31:0]      mem_addr_reg;
  logic [31:0]      mem_wdata_reg;
  logic [CNT_W-1:0] hdr_n;
  logic             accept;
  logic             restart;
  logic             word_valid;
  logic [31:0]      packed_word;

  assign accept  = in_valid && in_ready;
  assign restart = start && ((state_reg == DONE) || (state_reg == ERR));
  assign hdr_n   = CNT_W'({n_hi_reg, in_data});

  byte_word_packer u_packer (
    .clk        (clk),
    .clear      (reset || restart),
    .shift_en   (accept && (state_reg == DATA)),
    .in_byte    (in_data),
    .word_valid (word_valid),
    .word       (packed_word)
  );

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;

  // Running XOR of header and data bytes; restarted by the first header byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_reg <= '0;
    end else if (accept && (state_reg == HDR_HI)) begin
      csum_reg <= in_data;
    end else if (accept && ((state_reg == HDR_LO) || (state_reg == DATA))) begin
      csum_reg <= csum_reg ^ in_data;
    end
  end

  assign in_ready = (state_reg == HDR_HI) || (state_reg == HDR_LO) ||
                    (state_reg == DATA)   || (state_reg == CSUM);
`else
  assign in_ready = (state_reg == HDR_HI) || (state_reg == HDR_LO) ||
                    (state_reg == DATA);
`endif

  // Next-state logic for the header / data / write sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR_HI: if (accept) state_next = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_n == '0)                    state_next = AFTER_LAST;
          else if ({1'b0, hdr_n} > MAX_WORDS) state_next = ERR;
          else                                state_next = DATA;
        end
      end
      DATA:   if (word_valid) state_next = WRITE;
      WRITE:  state_next = ((idx_reg + CNT_W'(1)) == n_reg) ? AFTER_LAST : DATA;
`ifdef INST_LOADER_CHECKSUM_EN
      CSUM:   if (accept) state_next = (in_data == csum_reg) ? DONE : ERR;
`endif
      DONE:   if (start) state_next = HDR_HI;
      ERR:    if (start) state_next = HDR_HI;
      default: state_next = HDR_HI;
    endcase
  end

  // State, header, word index and registered write address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= HDR_HI;
      n_hi_reg      <= '0;
      n_reg         <= '0;
      idx_reg       <= '0;
      mem_addr_reg  <= BASE_ADDR;
      mem_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && (state_reg == HDR_HI)) n_hi_reg <= in_data;
      if (accept && (state_reg == HDR_LO)) begin
        n_reg   <= hdr_n;
        idx_reg <= '0;
      end
      if (state_reg == WRITE) idx_reg <= idx_reg + CNT_W'(1);
      if (word_valid) begin
        mem_wdata_reg <= packed_word;
        mem_addr_reg  <= BASE_ADDR + 32'({idx_reg, 2'b00});
      end
    end
  end

  assign mem_we    = (state_reg == WRITE);
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cpu_hold  = (state_reg != DONE);
  assign load_done = (state_reg == DONE);
  assign load_err  = (state_reg == ERR);

endmodule
